// File: rtl/prog_tick_counter.sv
// Programmable-period tick generator: counts enabled cycles up to a run-time period, pulses o_tick on wrap.
// Optional tick counter output enabled by defining PROG_TICK_COUNTER_WRAPCNT_EN.
module prog_tick_counter #(
  parameter int unsigned NB_COUNT       = 8,
  parameter int unsigned DEFAULT_PERIOD = 4
`ifdef PROG_TICK_COUNTER_WRAPCNT_EN
  ,
  parameter int unsigned NB_WRAP        = 16
`endif
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_start,
  input  logic                i_clear,
  input  logic                i_mode,
  input  logic [NB_COUNT-1:0] i_period,
  output logic [NB_COUNT-1:0] o_count,
  output logic                o_tick,
  output logic                o_busy,
  output logic                o_done
`ifdef PROG_TICK_COUNTER_WRAPCNT_EN
  ,
  output logic [NB_WRAP-1:0]  o_wrap_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [NB_COUNT-1:0] count_q, count_d;
  logic [NB_COUNT-1:0] period_q, period_d;
  logic                mode_q, mode_d;
  logic                tick_q, tick_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      period_q <= NB_COUNT'(DEFAULT_PERIOD);
      mode_q   <= 1'b0;
      tick_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      period_q <= period_d;
      mode_q   <= mode_d;
      tick_q   <= tick_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic; clear beats start beats counting
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    period_d = period_q;
    mode_d   = mode_q;
    tick_d   = 1'b0;
    if (i_clear) begin
      state_d = IDLE;
      count_d = '0;
    end else if (i_start) begin
      period_d = i_period;
      mode_d   = i_mode;
      count_d  = '0;
      state_d  = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (i_enable) begin
            if (count_q == period_q) begin
              count_d = '0;
              tick_d  = 1'b1;
              if (mode_q) state_d = DONE;
            end else begin
              count_d = count_q + NB_COUNT'(1);
            end
          end
        end
        DONE:    count_d = '0;
        default: ;
      endcase
    end
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  assign o_count = count_q;
  assign o_tick  = tick_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

`ifdef PROG_TICK_COUNTER_WRAPCNT_EN
  logic [NB_WRAP-1:0] wrap_q, wrap_d;

  // Saturating tick counter, advanced alongside the registered tick
  always_comb begin
    wrap_d = wrap_q;
    if (tick_d && (wrap_q != {NB_WRAP{1'b1}})) wrap_d = wrap_q + NB_WRAP'(1);
  end

  always_ff @(posedge clock) begin
    if (i_reset) wrap_q <= '0;
    else         wrap_q <= wrap_d;
  end

  assign o_wrap_cnt = wrap_q;
`endif

endmodule
